// File: rtl/frame_update_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_update_ctrl_pkg
// Description : Shared types and constants for the frame update controller.
//               Holds the FSM state enum, the data, BCD and drop-counter
//               widths, and the double-dabble digit adjust helper.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_update_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CONV_HR   = 2'd1,
        ST_CONV_SPO2 = 2'd2,
        ST_WAIT_VS   = 2'd3
    } fuc_state_e;

    localparam int DATA_W      = 24;
    localparam int BCD_DIGITS  = 8;
    localparam int BCD_W       = 32;
    localparam int CONV_CYCLES = 24;
    localparam int DROP_W      = 8;
    localparam int CONV_CNT_W  = $clog2(CONV_CYCLES + 1);

    // Double-dabble pre-shift correction: any digit of 5 or more gets +3 so
    // that the following left shift carries correctly into the next digit.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_update_ctrl_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble converter, one bit per clock.
//               A start pulse loads i_din; CONV_CYCLES iterations follow on
//               the next CONV_CYCLES clocks. o_done is high during the cycle
//               in which the last iteration is being applied, and o_dout
//               then carries that final (post-iteration) result, so the
//               caller can store it and restart on the same edge.
// Ports       : i_clk, i_rst_n (async, active low)
//               i_start  - load i_din and begin (overrides a running job)
//               i_din    - 24-bit binary input
//               o_done   - last-iteration cycle flag
//               o_dout   - 8-digit packed BCD, valid while o_done is high
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import frame_update_ctrl_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_din,
    output logic              o_done,
    output logic [BCD_W-1:0]  o_dout
);

    logic [DATA_W-1:0]     bin_q, bin_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic [CONV_CNT_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0]      w_adj;
    logic [BCD_W-1:0]      w_step;

    always_comb begin
        w_adj  = bcd_adjust(bcd_q);
        w_step = (w_adj << 1) | BCD_W'(bin_q[DATA_W-1]);
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        if (i_start) begin
            bin_d = i_din;
            bcd_d = '0;
            cnt_d = CONV_CNT_W'(CONV_CYCLES);
        end else if (cnt_q != '0) begin
            bin_d = bin_q << 1;
            bcd_d = w_step;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_done = (cnt_q == CONV_CNT_W'(1));
    assign o_dout = w_step;

endmodule
`default_nettype wire

// File: rtl/frame_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frame_update_ctrl
// Description : Captures each measurement set from the ALU, converts hr and
//               spo2 to packed BCD with one shared sequential converter, and
//               commits everything atomically on the vsync leading edge so
//               the display never changes mid-frame. A newer sample set
//               always replaces a pending one (counted in o_drop_cnt).
// Macro       : FRAME_UPD_BCD_EN - when defined, the BCD converter and the
//               CONV_HR/CONV_SPO2 states are built; otherwise a capture goes
//               straight to WAIT_VS and the BCD outputs stay 0.
// Ports       : i_clk, i_rst_n (async, active low)
//               i_hr/i_spo2/i_IR_raw/i_red_raw [23:0], i_ALU_DV strobe
//               i_VS vsync (polarity set by VS_ACTIVE_LOW)
//               o_hr/o_spo2/o_IR_raw/o_red_raw [23:0] committed binary
//               o_hr_bcd/o_spo2_bcd [31:0] committed BCD
//               o_ALU_DV commit pulse, o_busy converting, o_drop_cnt [7:0]
// Revision    : 1.0 - initial release
// ============================================================================
module frame_update_ctrl
    import frame_update_ctrl_pkg::*;
#(
    parameter logic VS_ACTIVE_LOW = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_hr,
    input  logic [DATA_W-1:0] i_spo2,
    input  logic [DATA_W-1:0] i_IR_raw,
    input  logic [DATA_W-1:0] i_red_raw,
    input  logic              i_ALU_DV,
    input  logic              i_VS,
    output logic [DATA_W-1:0] o_hr,
    output logic [DATA_W-1:0] o_spo2,
    output logic [DATA_W-1:0] o_IR_raw,
    output logic [DATA_W-1:0] o_red_raw,
    output logic [BCD_W-1:0]  o_hr_bcd,
    output logic [BCD_W-1:0]  o_spo2_bcd,
    output logic              o_ALU_DV,
    output logic              o_busy,
    output logic [DROP_W-1:0] o_drop_cnt
);

`ifdef FRAME_UPD_BCD_EN
    localparam fuc_state_e FIRST_STATE = ST_CONV_HR;
`else
    localparam fuc_state_e FIRST_STATE = ST_WAIT_VS;
`endif

    fuc_state_e        state_q, state_d;
    logic              vs_q, vs_d;           // previous cycle's sync level, asserted = 1
    logic [DATA_W-1:0] cap_hr_q, cap_hr_d, cap_spo2_q, cap_spo2_d;
    logic [DATA_W-1:0] cap_ir_q, cap_ir_d, cap_red_q, cap_red_d;
    logic [BCD_W-1:0]  hr_res_q, hr_res_d, spo2_res_q, spo2_res_d;
    logic [DATA_W-1:0] hr_out_q, hr_out_d, spo2_out_q, spo2_out_d;
    logic [DATA_W-1:0] ir_out_q, ir_out_d, red_out_q, red_out_d;
    logic [BCD_W-1:0]  hr_bcd_out_q, hr_bcd_out_d, spo2_bcd_out_q, spo2_bcd_out_d;
    logic              alu_dv_q, alu_dv_d, busy_q, busy_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              w_vs_level, w_vs_edge, w_restart, w_drop;
    logic              w_conv_start, w_conv_done;
    logic [DATA_W-1:0] w_conv_din;
    logic [BCD_W-1:0]  w_conv_dout;

`ifdef FRAME_UPD_BCD_EN
    bin2bcd_seq u_bin2bcd (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (w_conv_start),
        .i_din   (w_conv_din),
        .o_done  (w_conv_done),
        .o_dout  (w_conv_dout)
    );
`else
    logic w_unused_conv;
    assign w_conv_done   = 1'b0;
    assign w_conv_dout   = '0;
    assign w_unused_conv = &{1'b0, w_conv_start, w_conv_din};
`endif

    always_comb begin
        w_vs_level     = VS_ACTIVE_LOW ? ~i_VS : i_VS;
        w_vs_edge      = w_vs_level & ~vs_q;
        vs_d           = w_vs_level;
        state_d        = state_q;
        cap_hr_d       = cap_hr_q;
        cap_spo2_d     = cap_spo2_q;
        cap_ir_d       = cap_ir_q;
        cap_red_d      = cap_red_q;
        hr_res_d       = hr_res_q;
        spo2_res_d     = spo2_res_q;
        hr_out_d       = hr_out_q;
        spo2_out_d     = spo2_out_q;
        ir_out_d       = ir_out_q;
        red_out_d      = red_out_q;
        hr_bcd_out_d   = hr_bcd_out_q;
        spo2_bcd_out_d = spo2_bcd_out_q;
        alu_dv_d       = 1'b0;
        drop_d         = drop_q;
        w_restart      = 1'b0;
        w_drop         = 1'b0;
        w_conv_start   = 1'b0;
        w_conv_din     = i_hr;

        if (i_ALU_DV) begin
            cap_hr_d   = i_hr;
            cap_spo2_d = i_spo2;
            cap_ir_d   = i_IR_raw;
            cap_red_d  = i_red_raw;
        end

        case (state_q)
            ST_IDLE: begin
                w_restart = i_ALU_DV;
            end
            ST_CONV_HR: begin
                if (i_ALU_DV) begin
                    w_restart = 1'b1;
                    w_drop    = 1'b1;
                end else if (w_conv_done) begin
                    // hr finished: store it and hand the converter to spo2
                    hr_res_d     = w_conv_dout;
                    w_conv_start = 1'b1;
                    w_conv_din   = cap_spo2_q;
                    state_d      = ST_CONV_SPO2;
                end
            end
            ST_CONV_SPO2: begin
                if (i_ALU_DV) begin
                    w_restart = 1'b1;
                    w_drop    = 1'b1;
                end else if (w_conv_done) begin
                    spo2_res_d = w_conv_dout;
                    state_d    = ST_WAIT_VS;
                end
            end
            ST_WAIT_VS: begin
                if (w_vs_edge) begin
                    // Commit the pending set; a simultaneous new sample is
                    // simply the next job, not a superseded one.
                    hr_out_d       = cap_hr_q;
                    spo2_out_d     = cap_spo2_q;
                    ir_out_d       = cap_ir_q;
                    red_out_d      = cap_red_q;
                    hr_bcd_out_d   = hr_res_q;
                    spo2_bcd_out_d = spo2_res_q;
                    alu_dv_d       = 1'b1;
                    state_d        = ST_IDLE;
                    w_restart      = i_ALU_DV;
                end else if (i_ALU_DV) begin
                    w_restart = 1'b1;
                    w_drop    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_restart) begin
            state_d      = FIRST_STATE;
            w_conv_start = 1'b1;
            w_conv_din   = i_hr;
        end
        if (w_drop && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
        busy_d = (state_d == ST_CONV_HR) || (state_d == ST_CONV_SPO2);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= ST_IDLE;
            vs_q           <= 1'b0;
            cap_hr_q       <= '0;
            cap_spo2_q     <= '0;
            cap_ir_q       <= '0;
            cap_red_q      <= '0;
            hr_res_q       <= '0;
            spo2_res_q     <= '0;
            hr_out_q       <= '0;
            spo2_out_q     <= '0;
            ir_out_q       <= '0;
            red_out_q      <= '0;
            hr_bcd_out_q   <= '0;
            spo2_bcd_out_q <= '0;
            alu_dv_q       <= 1'b0;
            busy_q         <= 1'b0;
            drop_q         <= '0;
        end else begin
            state_q        <= state_d;
            vs_q           <= vs_d;
            cap_hr_q       <= cap_hr_d;
            cap_spo2_q     <= cap_spo2_d;
            cap_ir_q       <= cap_ir_d;
            cap_red_q      <= cap_red_d;
            hr_res_q       <= hr_res_d;
            spo2_res_q     <= spo2_res_d;
            hr_out_q       <= hr_out_d;
            spo2_out_q     <= spo2_out_d;
            ir_out_q       <= ir_out_d;
            red_out_q      <= red_out_d;
            hr_bcd_out_q   <= hr_bcd_out_d;
            spo2_bcd_out_q <= spo2_bcd_out_d;
            alu_dv_q       <= alu_dv_d;
            busy_q         <= busy_d;
            drop_q         <= drop_d;
        end
    end

    assign o_hr       = hr_out_q;
    assign o_spo2     = spo2_out_q;
    assign o_IR_raw   = ir_out_q;
    assign o_red_raw  = red_out_q;
    assign o_hr_bcd   = hr_bcd_out_q;
    assign o_spo2_bcd = spo2_bcd_out_q;
    assign o_ALU_DV   = alu_dv_q;
    assign o_busy     = busy_q;
    assign o_drop_cnt = drop_q;

endmodule
`default_nettype wire

// File: doc/frame_update_ctrl.md
# frame_update_ctrl

Schedules measurement updates into the TFT frame-storage path so the displayed values change only at a frame boundary, never mid-scan. Sits between the measurement ALU (hr, spo2, IR/red raw, ALU_DV strobe) and frame_storage. It captures each new sample set, converts hr and spo2 to packed BCD with one shared sequential double-dabble converter, then commits all values atomically on the leading edge of the TFT vertical sync.

## Interface
Parameters:
- VS_ACTIVE_LOW, 1, polarity of i_VS sync pulse (1: sync asserted when i_VS=0)

Ports:
- i_clk  in  1  system clock, same clock as my_tft and frame_storage
- i_rst_n  in  1  asynchronous, active-low reset
- i_hr, i_spo2, i_IR_raw, i_red_raw  in  24 each  measurement values, valid when i_ALU_DV=1
- i_ALU_DV  in  1  single-cycle strobe, new sample set valid
- i_VS  in  1  vertical sync from my_tft
- o_hr, o_spo2, o_IR_raw, o_red_raw  out  24 each  committed binary values to frame_storage
- o_hr_bcd, o_spo2_bcd  out  32 each  committed 8-digit packed BCD, digit 0 in [3:0]
- o_ALU_DV  out  1  one-cycle pulse on the commit cycle
- o_busy  out  1  high in CONV_HR/CONV_SPO2
- o_drop_cnt  out  8  count of sample sets discarded before commit, saturates at 255

## Operation
- Reset: every output 0; FSM IDLE; capture, result and converter registers 0; VS edge detector register loads the deasserted level.
- Capture registers load all four inputs on any cycle with i_ALU_DV=1.
- FSM states: IDLE, CONV_HR, CONV_SPO2, WAIT_VS.
  - IDLE: on i_ALU_DV capture, go to CONV_HR.
  - CONV_HR: 24 iterations, one per cycle: add 3 to every BCD nibble ≥5, then shift left one bit, taking in the binary MSB. After iteration 24, store the hr result and go to CONV_SPO2.
  - CONV_SPO2: identical 24 iterations on spo2. Store the result, then go to WAIT_VS.
  - WAIT_VS: on the vsync leading edge (deasserted→asserted), commit the capture and result registers to all outputs. Pulse o_ALU_DV. Go to IDLE.
- Latest sample wins:
  - i_ALU_DV in CONV_HR, CONV_SPO2 or WAIT_VS: recapture, restart at CONV_HR, and increment o_drop_cnt.
  - Exception: i_ALU_DV in the same cycle as the vsync edge in WAIT_VS. The pending set commits, the new set is captured, the next state is CONV_HR, and o_drop_cnt does not increment.
- Vsync edges in IDLE, CONV_HR or CONV_SPO2 are ignored. Outputs hold their last committed values.
- Binary inputs up to 16777215 convert exactly; there is no saturation or truncation.
- Asynchronous reset mid-conversion or in WAIT_VS discards everything. Outputs return to 0 immediately.

## Timing
- The i_ALU_DV cycle is N.
  - Capture occurs at the end of N.
  - o_busy is high for cycles N+1 to N+48.
  - WAIT_VS is entered at N+49.
- Commit latency is 1 cycle after the detected edge. The edge is seen in cycle E (i_VS registered previous level vs current). Outputs and the o_ALU_DV pulse appear in E+1.
- The earliest possible commit is N+50.
- If the vsync edge arrives before N+49, the commit waits for the next frame.
- o_ALU_DV is never high for more than 1 cycle, and at most once per vsync pulse.
- All outputs are registered.

## Configuration
- FRAME_UPD_BCD_EN defined: converter, CONV states and BCD outputs are present, as described above.
- Not defined: no converter. IDLE goes to WAIT_VS on the cycle after capture, so o_busy is constantly 0. o_hr_bcd and o_spo2_bcd are tied to 0. Drop and commit rules are unchanged, and the earliest commit is N+2.

## Structure
- A shared package holds:
  - the FSM state enum (2-bit);
  - the constants DATA_W=24, BCD_DIGITS=8, BCD_W=32, CONV_CYCLES=24;
  - the drop counter width of 8.
- Sub-module bin2bcd_seq (start, din[23:0], done, dout[31:0]) is instantiated once and time-shared between hr and spo2.
- The FSM, capture and commit registers stay in the top level.

## Test plan
- Reset release, i_hr=72, i_spo2=98, one DV pulse, VS edge at N+200 → at N+201 o_hr_bcd=32'h00000072, o_spo2_bcd=32'h00000098, o_hr=72, o_ALU_DV=1 for exactly 1 cycle.
- DV at N, VS edge at N+30 and N+1000 → no commit at N+31; commit at N+1001.
- Two DVs at N (hr=60) and N+10 (hr=61), VS edge later → committed o_hr=61 and o_hr_bcd=32'h00000061, o_drop_cnt=1.
- i_hr=24'hFFFFFF → o_hr_bcd=32'h16777215; 300 back-to-back superseded DVs → o_drop_cnt stays 255.
- DV coincident with VS edge in WAIT_VS → old set committed, o_drop_cnt unchanged, o_busy high next cycle. Reset asserted mid-CONV_SPO2 → all outputs 0 and no commit on the following VS.
